mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-ported unified memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the pipelined CPU. Sequences each access through issue, fixed-latency wait and completion. Returns read data with a one-cycle acknowledge pulse, and exposes per-requester stall signals that gate the PC/IFID write and freeze the pipeline.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from `mem_en` to valid `mem_rdata`; legal range 1..15

Ports:
- clk  in  1  single system clock, all logic on posedge
- nreset  in  1  reset; synchronous, active-high (asserted = 1)
- if_req  in  1  fetch request; held high with `if_addr` stable until `if_ack`
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word, valid in the `if_ack` cycle
- if_ack  out  1  one-cycle completion pulse
- dm_req  in  1  data request; held high with addr/wdata/we stable until `dm_ack`
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_rdata  out  DATA_W  read data, valid in the `dm_ack` cycle
- dm_ack  out  1  one-cycle completion pulse
- mem_en  out  1  memory access strobe, exactly one cycle per access
- mem_we  out  1  write enable, qualified by `mem_en`
- mem_addr  out  ADDR_W  memory address, qualified by `mem_en`
- mem_wdata  out  DATA_W  memory write data, qualified by `mem_en`
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the `mem_en` cycle
- stall_if  out  1  `if_req & ~if_ack`, combinational
- stall_mem  out  1  `dm_req & ~dm_ack`, combinational

## Operation
- FSM states:
  - IDLE: sample requests and choose grant.
    - Any request → ISSUE, owner latched (IF or DM).
    - No request → stay in IDLE.
  - ISSUE: `mem_en` = 1 with the owner's addr/we/wdata; load `wait_cnt` = MEM_LAT−1 → WAIT.
  - WAIT: decrement `wait_cnt`.
    - Count 0 → capture `mem_rdata` into the owner's rdata register and pulse the owner's ack → DONE.
    - With MEM_LAT = 1, WAIT is a single cycle.
  - DONE: ack is high this cycle; requests are ignored, because the requester still holds `req` in this cycle → IDLE.
- Arbitration in IDLE: only `dm_req` → DM; only `if_req` → IF; both pending → DM (the older instruction wins), unless overridden by Configuration.
- Writes follow the same sequence and ack timing. On a write, `dm_rdata` holds its previous value.
- `mem_we` is forced to 0 on IF grants; IF never writes.
- `mem_addr`, `mem_we` and `mem_wdata` are registered. They hold their last values outside ISSUE; only `mem_en` qualifies them.
- The non-owner requester sees no ack and stays stalled; its request is served on the next IDLE arbitration.
- A request that drops before its ack is a protocol violation. The access still completes and the ack still pulses.

## Timing
- Reset values: state IDLE, `mem_en` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `if_ack` 0, `dm_ack` 0, `if_rdata` 0, `dm_rdata` 0, `wait_cnt` 0, owner IF.
- Stall outputs follow the inputs, so during reset each stall equals its `req`.
- Latency: with `req` first high in cycle C and the FSM in IDLE:
  - `mem_en` in C+1
  - `mem_rdata` sampled in C+1+MEM_LAT
  - ack in C+2+MEM_LAT
- Throughput: one access per MEM_LAT+3 cycles. With MEM_LAT = 2, that is one access every 5 cycles.
- Reset mid-operation: abort, return to IDLE on the next edge, no ack issued, and the late `mem_rdata` is discarded.
- `if_ack` and `dm_ack` are never high in the same cycle.

## Configuration
- ARB_FAIR_EN defined: a last-granted flag (reset = IF) is updated at each grant.
  - When both requests are pending in IDLE, the grant goes to the side not granted last, so strict alternation under continuous contention.
  - With only one request pending, the rules are unchanged.
- ARB_FAIR_EN undefined: fixed DM priority; IF can starve under continuous `dm_req`.

## Test plan
- Reset, then `if_req` = 1 with `if_addr` = 0x10 in cycle 0, MEM_LAT = 2, and memory returning 0xDEADBEEF → `mem_en` with `mem_addr` = 0x10 in cycle 1, `if_ack` with `if_rdata` = 0xDEADBEEF in cycle 4, `stall_if` = 0 from cycle 4.
- `if_req` and `dm_req` both raised in cycle 0 (dm read 0x40), ARB_FAIR_EN off → `dm_ack` in cycle 4 and `if_ack` in cycle 9; `stall_if` stays high through cycle 8.
- `dm_req` held continuously with `if_req` high, ARB_FAIR_EN on → grants alternate DM, IF, DM, IF; acks in cycles 4, 9, 14, 19.
- `dm_we` = 1, `dm_addr` = 0x20, `dm_wdata` = 0x1234 → single `mem_en` cycle with `mem_we` = 1, `mem_wdata` = 0x1234; `dm_ack` in cycle 4; `dm_rdata` unchanged.
- `nreset` asserted in WAIT (cycle 2) of a fetch → no `if_ack`, all outputs at reset values in cycle 3; a new request after deassertion completes with normal latency.
- MEM_LAT = 1 back-to-back fetches with `req` held → acks exactly 4 cycles apart, no duplicate grant from the request still held in the DONE cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch (IF) and data (DM) requesters.
// Optional macro ARB_FAIR_EN: alternate grants under contention instead of fixed DM priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_reg;
  logic              owner_dm_reg;
  logic [3:0]        wait_cnt_reg;
  logic              mem_en_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic              if_ack_reg;
  logic              dm_ack_reg;
  logic [DATA_W-1:0] if_rdata_reg;
  logic [DATA_W-1:0] dm_rdata_reg;
  logic              grant_dm;

`ifdef ARB_FAIR_EN
  logic last_dm_reg;

  // Under contention the side that did not win last time gets the grant.
  always_comb begin
    grant_dm = dm_req & (~if_req | ~last_dm_reg);
  end
`else
  always_comb begin
    grant_dm = dm_req;
  end
`endif

  always_ff @(posedge clk) begin
    if (nreset) begin
      state_reg     <= IDLE;
      owner_dm_reg  <= 1'b0;
      wait_cnt_reg  <= 4'd0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_ack_reg    <= 1'b0;
      dm_ack_reg    <= 1'b0;
      if_rdata_reg  <= '0;
      dm_rdata_reg  <= '0;
`ifdef ARB_FAIR_EN
      last_dm_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (if_req || dm_req) begin
            state_reg    <= ISSUE;
            owner_dm_reg <= grant_dm;
            mem_en_reg   <= 1'b1;
            mem_we_reg   <= grant_dm & dm_we;
            mem_addr_reg <= grant_dm ? dm_addr : if_addr;
            if (grant_dm) begin
              mem_wdata_reg <= dm_wdata;
            end
`ifdef ARB_FAIR_EN
            last_dm_reg  <= grant_dm;
`endif
          end
        end
        ISSUE: begin
          mem_en_reg   <= 1'b0;
          wait_cnt_reg <= 4'(MEM_LAT - 1);
          state_reg    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt_reg == 4'd0) begin
            state_reg <= DONE;
            if (owner_dm_reg) begin
              dm_ack_reg <= 1'b1;
              // Writes leave the previously returned read data in place.
              if (!mem_we_reg) begin
                dm_rdata_reg <= mem_rdata;
              end
            end else begin
              if_ack_reg   <= 1'b1;
              if_rdata_reg <= mem_rdata;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end
        DONE: begin
          // Requests are still held this cycle, so arbitration waits for IDLE.
          if_ack_reg <= 1'b0;
          dm_ack_reg <= 1'b0;
          state_reg  <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign if_ack    = if_ack_reg;
  assign dm_ack    = dm_ack_reg;
  assign if_rdata  = if_rdata_reg;
  assign dm_rdata  = dm_rdata_reg;
  assign stall_if  = if_req & ~if_ack_reg;
  assign stall_mem = dm_req & ~dm_ack_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, contention/reset/latency sequences, random traffic vs a cycle-arithmetic model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        nreset;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ack, dm_ack, mem_en, mem_we, stall_if, stall_mem;
  logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        if_ack1, dm_ack1, mem_en1, mem_we1, stall_if1, stall_mem1;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .nreset(nreset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .nreset(nreset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata1), .if_ack(if_ack1),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata1), .dm_ack(dm_ack1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .stall_if(stall_if1), .stall_mem(stall_mem1)
  );

  // Environment memory: returns data exactly LAT cycles after the mem_en cycle, junk otherwise.
  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] rd_pipe [0:LAT-1];
  logic [31:0] rd_pipe1;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] env_read(input logic [31:0] a);
    if (env_mem.exists(a)) return env_mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  always @(posedge clk) begin
    rd_pipe[0] <= (mem_en && !mem_we) ? env_read(mem_addr) : $urandom;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe1 <= (mem_en1 && !mem_we1) ? env_read(mem_addr1) : $urandom;
    if (mem_en && mem_we) env_mem[mem_addr] = mem_wdata;
  end
  assign mem_rdata  = rd_pipe[LAT-1];
  assign mem_rdata1 = rd_pipe1;

  // Reference model: one access occupies the port for LAT+3 cycles from its grant cycle.
  int          cyc;
  int          n_cmp = 0, n_bad = 0;
  bit          m_active, m_owner_dm, m_we, m_last_dm;
  int          m_en_cyc, m_ack_cyc, m_free_at;
  logic [31:0] m_addr, m_wdata, m_data, exp_if_rdata, exp_dm_rdata;
  bit          seen_if_ack, seen_dm_ack, seen_if_ack1;
  logic [31:0] snap_if, snap_dm, snap_if1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    bit e_if, e_dm, e_en, gdm;
    @(negedge clk);
    e_en = m_active && (cyc == m_en_cyc);
    e_if = m_active && (cyc == m_ack_cyc) && !m_owner_dm;
    e_dm = m_active && (cyc == m_ack_cyc) && m_owner_dm;
    if (e_if) exp_if_rdata = m_data;
    if (e_dm && !m_we) exp_dm_rdata = m_data;
    chk("if_ack", {31'b0, if_ack}, {31'b0, e_if});
    chk("dm_ack", {31'b0, dm_ack}, {31'b0, e_dm});
    chk("mem_en", {31'b0, mem_en}, {31'b0, e_en});
    if (e_en) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", {31'b0, mem_we}, {31'b0, m_we});
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("if_rdata", if_rdata, exp_if_rdata);
    chk("dm_rdata", dm_rdata, exp_dm_rdata);
    chk("stall_if", {31'b0, stall_if}, {31'b0, if_req & ~e_if});
    chk("stall_mem", {31'b0, stall_mem}, {31'b0, dm_req & ~e_dm});
    seen_if_ack = if_ack;  seen_dm_ack = dm_ack;  seen_if_ack1 = if_ack1;
    snap_if = if_rdata;    snap_dm = dm_rdata;    snap_if1 = if_rdata1;
    if (m_active && cyc == m_ack_cyc) m_active = 0;
    if (nreset) begin
      m_active = 0; m_free_at = cyc + 1; m_last_dm = 0;
      exp_if_rdata = '0; exp_dm_rdata = '0;
    end else if (cyc >= m_free_at && (if_req || dm_req)) begin
      if (if_req && dm_req) begin
`ifdef ARB_FAIR_EN
        gdm = !m_last_dm;
`else
        gdm = 1'b1;
`endif
      end else begin
        gdm = dm_req;
      end
      m_last_dm = gdm; m_active = 1; m_owner_dm = gdm;
      m_en_cyc = cyc + 1; m_ack_cyc = cyc + 2 + LAT; m_free_at = cyc + 3 + LAT;
      m_addr = gdm ? dm_addr : if_addr;
      m_we = gdm && dm_we;
      m_wdata = dm_wdata;
      if (m_we) ref_mem[m_addr] = m_wdata;
      m_data = m_we ? 32'h0 : ref_read(m_addr);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    nreset = 1'b1; if_req = 0; dm_req = 0;
    tick();
    nreset = 1'b0;
    repeat (2) tick();
  endtask

  typedef struct {
    bit          ir;
    logic [31:0] ia;
    bit          dr;
    bit          dw;
    logic [31:0] da;
    logic [31:0] dd;
    int          e_if_cyc;
    int          e_dm_cyc;
    logic [31:0] e_if_data;
    logic [31:0] e_dm_data;
  } vec_t;

  vec_t vecs [6];
  int   c0, got_if, got_dm;
  logic [31:0] got_ifd, got_dmd;
  int   q_rel [$];
  bit   q_dm [$];
  int   acks1 [$];
  logic [31:0] first_d1;

  initial begin
    nreset = 1'b1; if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    env_mem[32'h10] = 32'hDEADBEEF; ref_mem[32'h10] = 32'hDEADBEEF;
    env_mem[32'h40] = 32'hCAFE0040; ref_mem[32'h40] = 32'hCAFE0040;
    m_active = 0; m_last_dm = 0; m_free_at = 0;
    exp_if_rdata = '0; exp_dm_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    cyc = 0;
    // Reset values of the registered memory-side outputs.
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    if_req = 1'b1; if_addr = 32'h10;
    tick();                       // stall equals req while reset is held
    if_req = 1'b0;
    nreset = 1'b0;
    repeat (2) tick();

    vecs[0] = '{1, 32'h10, 0, 0, 32'h0,  32'h0,      2+LAT, -1,    32'hDEADBEEF, 32'h0};
    vecs[1] = '{1, 32'h14, 1, 0, 32'h40, 32'h0,      7+LAT, 2+LAT, init_val(32'h14), 32'hCAFE0040};
    vecs[2] = '{0, 32'h0,  1, 1, 32'h20, 32'h1234,   -1,    2+LAT, 32'h0,        32'hCAFE0040};
    vecs[3] = '{0, 32'h0,  1, 0, 32'h20, 32'h0,      -1,    2+LAT, 32'h0,        32'h1234};
`ifdef ARB_FAIR_EN
    vecs[4] = '{1, 32'h20, 1, 1, 32'h24, 32'hABCD,   2+LAT, 7+LAT, 32'h1234,     32'h1234};
`else
    vecs[4] = '{1, 32'h20, 1, 1, 32'h24, 32'hABCD,   7+LAT, 2+LAT, 32'h1234,     32'h1234};
`endif
    vecs[5] = '{1, 32'h24, 0, 0, 32'h0,  32'h0,      2+LAT, -1,    32'hABCD,     32'h1234};

    for (int v = 0; v < 6; v++) begin
      got_if = -1; got_dm = -1; got_ifd = '0; got_dmd = '0;
      if_req = vecs[v].ir; if_addr = vecs[v].ia;
      dm_req = vecs[v].dr; dm_we = vecs[v].dw; dm_addr = vecs[v].da; dm_wdata = vecs[v].dd;
      c0 = cyc;
      for (int k = 0; k < 14; k++) begin
        tick();
        if (seen_if_ack) begin got_if = cyc - 1 - c0; got_ifd = snap_if; if_req = 0; end
        if (seen_dm_ack) begin got_dm = cyc - 1 - c0; got_dmd = snap_dm; dm_req = 0; end
      end
      chk($sformatf("vec%0d_if_ack_cycle", v), got_if, vecs[v].e_if_cyc);
      chk($sformatf("vec%0d_dm_ack_cycle", v), got_dm, vecs[v].e_dm_cyc);
      if (vecs[v].ir) chk($sformatf("vec%0d_if_rdata", v), got_ifd, vecs[v].e_if_data);
      if (vecs[v].dr) chk($sformatf("vec%0d_dm_rdata", v), got_dmd, vecs[v].e_dm_data);
      $display("vec %0d: if_ack@%0d dm_ack@%0d if_rdata=%h dm_rdata=%h", v, got_if, got_dm, got_ifd, got_dmd);
    end

    // Continuous contention: both requests held for 22 cycles.
    do_reset();
    if_req = 1; if_addr = 32'h10; dm_req = 1; dm_we = 0; dm_addr = 32'h40;
    c0 = cyc;
    for (int k = 0; k < 22; k++) begin
      tick();
      if (seen_if_ack || seen_dm_ack) begin q_rel.push_back(cyc - 1 - c0); q_dm.push_back(seen_dm_ack); end
    end
    if_req = 0; dm_req = 0;
    repeat (6) tick();
    chk("contention_ack_count", q_rel.size(), 4);
    for (int i = 0; i < 4 && i < q_rel.size(); i++) begin
      chk($sformatf("contention_ack%0d_cycle", i), q_rel[i], 4 + 5 * i);
`ifdef ARB_FAIR_EN
      chk($sformatf("contention_ack%0d_owner_dm", i), {31'b0, q_dm[i]}, {31'b0, (i % 2) == 0});
`else
      chk($sformatf("contention_ack%0d_owner_dm", i), {31'b0, q_dm[i]}, 32'h1);
`endif
      $display("contention ack %0d at cycle %0d owner_dm=%0d", i, q_rel[i], q_dm[i]);
    end

    // Reset asserted in the first WAIT cycle of a fetch.
    if_req = 1; if_addr = 32'h10;
    tick(); tick();
    nreset = 1;
    tick();
    nreset = 0; if_req = 0;
    chk("abort_mem_addr", mem_addr, 32'h0);
    chk("abort_mem_we", {31'b0, mem_we}, 32'h0);
    chk("abort_mem_wdata", mem_wdata, 32'h0);
    repeat (5) tick();
    if_req = 1; if_addr = 32'h44; got_if = -1; got_ifd = '0;
    c0 = cyc;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (seen_if_ack) begin got_if = cyc - 1 - c0; got_ifd = snap_if; if_req = 0; end
    end
    chk("post_reset_if_ack_cycle", got_if, 2 + LAT);
    chk("post_reset_if_rdata", got_ifd, init_val(32'h44));
    $display("post-reset fetch: if_ack@%0d if_rdata=%h", got_if, got_ifd);

    // MEM_LAT=1 instance: held fetch request, acks every 4 cycles.
    do_reset();
    if_req = 1; if_addr = 32'h10; first_d1 = '0;
    c0 = cyc;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (seen_if_ack1) begin
        if (acks1.size() == 0) first_d1 = snap_if1;
        acks1.push_back(cyc - 1 - c0);
      end
    end
    if_req = 0;
    repeat (6) tick();
    chk("lat1_ack_count", acks1.size(), 4);
    for (int i = 0; i < 4 && i < acks1.size(); i++) begin
      chk($sformatf("lat1_ack%0d_cycle", i), acks1[i], 3 + 4 * i);
      $display("lat1 ack %0d at cycle %0d", i, acks1[i]);
    end
    chk("lat1_if_rdata", first_d1, 32'hDEADBEEF);

    // Random traffic with occasional resets, checked every cycle by the model.
    for (int k = 0; k < 800; k++) begin
      if (seen_if_ack) if_req = 0;
      if (seen_dm_ack) dm_req = 0;
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = 32'h100 + 32'($urandom_range(0, 15)) * 4;
      end
      if (!dm_req && $urandom_range(0, 2) == 0) begin
        dm_req = 1; dm_we = 1'($urandom_range(0, 1));
        dm_addr = 32'h100 + 32'($urandom_range(0, 15)) * 4; dm_wdata = $urandom;
      end
      nreset = ($urandom_range(0, 149) == 0);
      if (nreset) begin if_req = 0; dm_req = 0; end
      tick();
      if (seen_if_ack || seen_dm_ack)
        $display("rand cycle %0d: if_ack=%0d dm_ack=%0d if_rdata=%h dm_rdata=%h", cyc - 1, seen_if_ack, seen_dm_ack, snap_if, snap_dm);
    end
    nreset = 0; if_req = 0; dm_req = 0;
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
